y86_prog_loader: RTL and testbench

Byte-serial program loader sitting directly upstream of the Y86-64 instruction memory. Accepts a framed program image (2-byte length, payload, 1-byte XOR checksum) over a valid/ready byte stream. Writes the payload into instruction memory starting at address 0, then holds the processor in run until it reports a non-AOK status. Replaces hand-driven writes to the instruction memory's write port and provides the processor's run/hold gate.

---
 rtl/y86_pkg.sv | 23 ++
 rtl/y86_prog_loader.sv | 174 +++++++++++++++++
 tb/tb_y86_prog_loader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 program loader: FSM states, processor
// status codes and frame field widths.
package y86_pkg;

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned STAT_W = 2;

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [STAT_W-1:0] STAT_AOK = 2'd0;
  localparam logic [STAT_W-1:0] STAT_HLT = 2'd1;
  localparam logic [STAT_W-1:0] STAT_ADR = 2'd2;
  localparam logic [STAT_W-1:0] STAT_INS = 2'd3;

endpackage

// File: rtl/y86_prog_loader.sv
// Byte-serial framed program loader feeding the Y86-64 instruction memory
// write port, and run/hold gate for the processor.
module y86_prog_loader
  import y86_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  input  logic [1:0]        stat,
  output logic              imem_wEn,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              cpu_run,
  output logic              load_err,
  output logic              done,
  output logic [1:0]        halt_stat
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  // Largest legal length (full memory), one bit wider than len so it fits.
  localparam logic [LEN_W:0] MAX_LEN = {{(LEN_W - ADDR_W){1'b0}}, 1'b1, {ADDR_W{1'b0}}};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    w_len_nxt;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [BYTE_W-1:0]   r_xor;
  logic [BYTE_W-1:0]   w_xor_nxt;

  logic                r_wen;
  logic                w_wen_nxt;
  logic [ADDR_W-1:0]   r_waddr;
  logic [ADDR_W-1:0]   w_waddr_nxt;
  logic [BYTE_W-1:0]   r_wdata;
  logic [BYTE_W-1:0]   w_wdata_nxt;
  logic                r_run;
  logic                w_run_nxt;
  logic                r_err;
  logic                w_err_nxt;
  logic                r_done;
  logic                w_done_nxt;
  logic [STAT_W-1:0]   r_halt;
  logic [STAT_W-1:0]   w_halt_nxt;

  logic                w_accept;
  logic                w_ready;
  logic [LEN_W-1:0]    w_len_full;
  logic [CNT_W-1:0]    w_count_inc;

  assign w_ready     = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                       (r_state == S_DATA) || (r_state == S_CSUM);
  assign in_ready    = w_ready && !rst;
  assign w_accept    = in_valid && in_ready;
  assign w_len_full  = {in_byte, r_len[7:0]};
  assign w_count_inc = r_count + CNT_W'(1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LEN0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, datapath and registered-output next values.
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_count_nxt = r_count;
    w_xor_nxt   = r_xor;
    w_wen_nxt   = 1'b0;
    w_waddr_nxt = r_waddr;
    w_wdata_nxt = r_wdata;
    w_done_nxt  = 1'b0;
    w_halt_nxt  = r_halt;

    case (r_state)
      S_LEN0: begin
        if (w_accept) begin
          w_len_nxt   = {r_len[15:8], in_byte};
          w_state_nxt = S_LEN1;
        end
      end
      S_LEN1: begin
        if (w_accept) begin
          w_len_nxt = w_len_full;
          if ((w_len_full == '0) || ({1'b0, w_len_full} > MAX_LEN)) begin
            w_state_nxt = S_ERR;
          end else begin
            w_count_nxt = '0;
            w_xor_nxt   = '0;
            w_state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_accept) begin
          w_wen_nxt   = 1'b1;
          w_waddr_nxt = r_count[ADDR_W-1:0];
          w_wdata_nxt = in_byte;
          w_xor_nxt   = r_xor ^ in_byte;
          w_count_nxt = w_count_inc;
          if (LEN_W'(w_count_inc) == r_len) begin
            w_state_nxt = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (w_accept) begin
          w_state_nxt = (in_byte == r_xor) ? S_RUN : S_ERR;
        end
      end
      S_RUN: begin
        if (stat != STAT_AOK) begin
          w_halt_nxt  = stat;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_LEN0;
        end
      end
      S_ERR: begin
        w_state_nxt = S_ERR;
      end
      default: begin
        w_state_nxt = S_LEN0;
      end
    endcase

    w_run_nxt = (w_state_nxt == S_RUN);
    w_err_nxt = (w_state_nxt == S_ERR);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len   <= '0;
      r_count <= '0;
      r_xor   <= '0;
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_run   <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_halt  <= '0;
    end else begin
      r_len   <= w_len_nxt;
      r_count <= w_count_nxt;
      r_xor   <= w_xor_nxt;
      r_wen   <= w_wen_nxt;
      r_waddr <= w_waddr_nxt;
      r_wdata <= w_wdata_nxt;
      r_run   <= w_run_nxt;
      r_err   <= w_err_nxt;
      r_done  <= w_done_nxt;
      r_halt  <= w_halt_nxt;
    end
  end

  assign imem_wEn   = r_wen;
  assign imem_addr  = r_waddr;
  assign imem_wdata = r_wdata;
  assign cpu_run    = r_run;
  assign load_err   = r_err;
  assign done       = r_done;
  assign halt_stat  = r_halt;

endmodule

// File: tb/tb_y86_prog_loader.sv
// Directed self-checking bench for y86_prog_loader (ADDR_W = 10).
module tb_y86_prog_loader;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic [1:0]        stat;
  logic              imem_wEn;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_wdata;
  logic              cpu_run;
  logic              load_err;
  logic              done;
  logic [1:0]        halt_stat;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int        wa[$];
  logic [7:0] wd[$];
  int        wc[$];
  logic      wr[$];

  y86_prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .stat       (stat),
    .imem_wEn   (imem_wEn),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .load_err   (load_err),
    .done       (done),
    .halt_stat  (halt_stat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every memory write, when it happened and whether the CPU was running.
  always @(negedge clk) begin
    if (imem_wEn) begin
      wa.push_back(int'(imem_addr));
      wd.push_back(imem_wdata);
      wc.push_back(cyc);
      wr.push_back(cpu_run);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete(); wr.delete();
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("send_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),   32'd0);
    check({tag, "_wEn"},       32'(imem_wEn),   32'd0);
    check({tag, "_addr"},      32'(imem_addr),  32'd0);
    check({tag, "_wdata"},     32'(imem_wdata), 32'd0);
    check({tag, "_cpu_run"},   32'(cpu_run),    32'd0);
    check({tag, "_load_err"},  32'(load_err),   32'd0);
    check({tag, "_done"},      32'(done),       32'd0);
    check({tag, "_halt_stat"}, 32'(halt_stat),  32'd0);
  endtask

  initial begin
    logic [7:0] x;
    logic [7:0] b;
    int bad;

    rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; stat = 2'd0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_ready", 32'(in_ready), 32'd1);

    // Good 3-byte frame: 30^F0^10 = D0.
    clear_log();
    send(8'h03); send(8'h00); send(8'h30); send(8'hF0); send(8'h10);
    check("frame1_run_before_csum", 32'(cpu_run), 32'd0);
    send(8'hD0);
    check("frame1_cpu_run", 32'(cpu_run), 32'd1);
    check("frame1_load_err", 32'(load_err), 32'd0);
    check("frame1_in_ready", 32'(in_ready), 32'd0);
    idle(1);
    check("frame1_nwrites", 32'(wa.size()), 32'd3);
    if (wa.size() == 3) begin
      check("frame1_a0", 32'(wa[0]), 32'd0); check("frame1_d0", 32'(wd[0]), 32'h30);
      check("frame1_a1", 32'(wa[1]), 32'd1); check("frame1_d1", 32'(wd[1]), 32'hF0);
      check("frame1_a2", 32'(wa[2]), 32'd2); check("frame1_d2", 32'(wd[2]), 32'h10);
      check("frame1_b2b_01", 32'(wc[1] - wc[0]), 32'd1);
      check("frame1_b2b_12", 32'(wc[2] - wc[1]), 32'd1);
      check("frame1_last_wr_no_run", 32'(wr[2]), 32'd0);
    end

    // Run for 5 AOK cycles, then HLT.
    repeat (5) begin
      @(posedge clk); #1;
      check("run_aok_cpu_run", 32'(cpu_run), 32'd1);
      check("run_aok_done", 32'(done), 32'd0);
    end
    stat = 2'd1;
    @(posedge clk); #1;
    stat = 2'd0;
    check("hlt_done", 32'(done), 32'd1);
    check("hlt_halt_stat", 32'(halt_stat), 32'd1);
    check("hlt_cpu_run", 32'(cpu_run), 32'd0);
    check("hlt_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("hlt_done_once", 32'(done), 32'd0);

    // Second frame after a run: AA^55 = FF; ends on ADR.
    clear_log();
    send(8'h02); send(8'h00); send(8'hAA); send(8'h55); send(8'hFF);
    check("frame2_cpu_run", 32'(cpu_run), 32'd1);
    idle(1);
    check("frame2_nwrites", 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      check("frame2_a0", 32'(wa[0]), 32'd0); check("frame2_d0", 32'(wd[0]), 32'hAA);
      check("frame2_a1", 32'(wa[1]), 32'd1); check("frame2_d1", 32'(wd[1]), 32'h55);
    end
    stat = 2'd2;
    @(posedge clk); #1;
    stat = 2'd0;
    check("adr_done", 32'(done), 32'd1);
    check("adr_halt_stat", 32'(halt_stat), 32'd2);

    // Bad checksum is sticky until reset.
    send(8'h03); send(8'h00); send(8'h30); send(8'hF0); send(8'h10); send(8'h00);
    check("badcs_load_err", 32'(load_err), 32'd1);
    check("badcs_cpu_run", 32'(cpu_run), 32'd0);
    check("badcs_in_ready", 32'(in_ready), 32'd0);
    stat = 2'd3;
    idle(4);
    stat = 2'd0;
    check("badcs_sticky_err", 32'(load_err), 32'd1);
    check("badcs_sticky_ready", 32'(in_ready), 32'd0);
    check("badcs_stat_ignored", 32'(done), 32'd0);
    do_reset();
    check("badcs_reset_err", 32'(load_err), 32'd0);

    // Zero length.
    clear_log();
    send(8'h00); send(8'h00);
    check("len0_load_err", 32'(load_err), 32'd1);
    check("len0_in_ready", 32'(in_ready), 32'd0);
    idle(3);
    check("len0_nwrites", 32'(wa.size()), 32'd0);
    do_reset();

    // Length 1025 exceeds a 1024-byte memory.
    clear_log();
    send(8'h01); send(8'h04);
    check("len1025_load_err", 32'(load_err), 32'd1);
    idle(3);
    check("len1025_nwrites", 32'(wa.size()), 32'd0);
    do_reset();

    // Full-memory frame of 1024 bytes.
    clear_log();
    x = 8'h00;
    send(8'h00); send(8'h04);
    for (int i = 0; i < 1024; i++) begin
      b = 8'(i * 7 + 3);
      x = x ^ b;
      send(b);
    end
    send(x);
    check("full_cpu_run", 32'(cpu_run), 32'd1);
    check("full_load_err", 32'(load_err), 32'd0);
    idle(1);
    check("full_nwrites", 32'(wa.size()), 32'd1024);
    if (wa.size() == 1024) begin
      bad = 0;
      for (int i = 0; i < 1024; i++) begin
        if (wa[i] != i || wd[i] != 8'(i * 7 + 3)) bad++;
      end
      check("full_contents", 32'(bad), 32'd0);
      check("full_last_addr", 32'(wa[1023]), 32'h3FF);
    end
    stat = 2'd3;
    @(posedge clk); #1;
    stat = 2'd0;
    check("full_ins_halt_stat", 32'(halt_stat), 32'd3);

    // Reset mid-payload, then a fresh frame.
    send(8'h03); send(8'h00); send(8'h11); send(8'h22);
    check("midrst_pre_wEn", 32'(imem_wEn), 32'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    clear_log();
    send(8'h01); send(8'h00); send(8'h5A); send(8'h5A);
    check("after_rst_cpu_run", 32'(cpu_run), 32'd1);
    idle(1);
    check("after_rst_nwrites", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      check("after_rst_a0", 32'(wa[0]), 32'd0);
      check("after_rst_d0", 32'(wd[0]), 32'h5A);
    end
    stat = 2'd1;
    @(posedge clk); #1;
    stat = 2'd0;
    check("after_rst_done", 32'(done), 32'd1);
    check("after_rst_halt", 32'(halt_stat), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
